decoder_strobe: RTL and testbench

Sequential 3-to-8 one-hot decoder: the receive-side counterpart of the team's 8-to-3 `encoder`. It accepts binary codes over a valid/ready handshake and buffers them in a small FIFO. For each code it drives the matching one-hot output line as a fixed-width strobe, followed by a one-cycle all-zero gap. It sits between a code source (e.g. `encoder` output plus a valid) and downstream logic that needs clean, separated, one-hot select pulses.

---
 rtl/decoder_strobe.sv | 118 +++++++++++
 tb/tb_decoder_strobe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_strobe.sv
// decoder_strobe: buffered 3-to-8 one-hot decoder with fixed-width strobes.
// Codes arrive over a valid/ready handshake into a small circular FIFO. Each
// code is played out as a one-hot strobe on y for HOLD cycles, followed by a
// one-cycle all-zero gap during which done pulses.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   en        - launch enable; gates only the start of new strobes
//   din       - code to decode
//   din_valid - din is valid; pushed when din_valid && din_ready
//   din_ready - FIFO not full (derived from registered level)
//   y         - registered one-hot strobe, zero when idle
//   done      - registered one-cycle pulse in the gap after each strobe
//   busy      - FSM not idle or FIFO non-empty
//   level     - FIFO occupancy
module decoder_strobe #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [IN_W-1:0]            din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [(1<<IN_W)-1:0]       y,
  output logic                       done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned OW = 1 << IN_W;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t          state, state_d;
  logic [OW-1:0]   y_d;
  logic            done_d;
  logic [CW-1:0]   hold_cnt, hold_cnt_d;
  logic [IN_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic            full, empty, push, pop;

  // FIFO status comes from the registered level only, so a pop never
  // frees a slot for a push in the same cycle.
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign din_ready = !full;
  assign push      = din_valid && !full;
  assign busy      = (state != IDLE) || !empty;

  // Next-state and output decode
  always_comb begin
    state_d    = state;
    y_d        = y;
    done_d     = 1'b0;
    hold_cnt_d = hold_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop        = 1'b1;
          y_d        = OW'(1) << mem[rptr];
          hold_cnt_d = CW'(HOLD - 1);
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_cnt == '0) begin
          y_d     = '0;
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          hold_cnt_d = hold_cnt - CW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        y_d     = '0;
      end
    endcase
  end

  // State, output and FIFO control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      y        <= '0;
      done     <= 1'b0;
      hold_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
    end else begin
      state    <= state_d;
      y        <= y_d;
      done     <= done_d;
      hold_cnt <= hold_cnt_d;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      level    <= level + LW'(push) - LW'(pop);
    end
  end

  // FIFO storage; contents need no reset since pointers are flushed
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wptr] <= din;
  end

endmodule

// File: tb/tb_decoder_strobe.sv
// Self-checking bench for decoder_strobe: a vector table for reset, single
// code and FIFO fill, plus hand-written sequences for streaming order, en
// drop, mid-strobe reset and simultaneous push/pop (HOLD=4 and HOLD=1).
module tb_decoder_strobe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] din = '0;
  logic       din_valid = 1'b0;

  logic       rdy0, done0, busy0, rdy1, done1, busy1;
  logic [7:0] y0, y1;
  logic [2:0] level0, level1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_strobe #(.IN_W(3), .HOLD(4), .DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .y(y0), .done(done0), .busy(busy0), .level(level0)
  );

  decoder_strobe #(.IN_W(3), .HOLD(1), .DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .y(y1), .done(done1), .busy(busy1), .level(level1)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       vld;
    logic [2:0] din;
    logic [7:0] y;
    logic       done;
    logic       busy;
    logic       rdy;
    logic [2:0] level;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input logic [2:0] d, input logic [7:0] ey,
                              input logic ed, input logic eb, input logic er,
                              input logic [2:0] el);
    vec_t t;
    t.rst_n = r; t.en = e; t.vld = v; t.din = d;
    t.y = ey; t.done = ed; t.busy = eb; t.rdy = er; t.level = el;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no strobe expected strobe within bound at %0t", nm, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] obs(input bit inst);
    return inst ? {y1, done1, busy1} : {y0, done0, busy0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; din_valid = 1'b0; din = '0;
    step();
    rst_n = 1'b1;
  endtask

  // Push one code on u0's handshake, bounded wait for acceptance
  task automatic push(input logic [2:0] d);
    logic acc;
    din = d;
    din_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      acc = rdy0;
      step();
      if (acc) begin
        din_valid = 1'b0;
        return;
      end
    end
    din_valid = 1'b0;
    timeout("push_accept");
  endtask

  // Expect strobes for n codes: hold cycles one-hot, one done gap, one idle
  task automatic check_stream(input bit inst, input logic [23:0] codes, input int n,
                              input int hold, input bit end_empty);
    logic [9:0] o;
    logic [2:0] code;
    o = obs(inst);
    for (int k = 0; k < 50 && o[9:2] == 8'h00; k++) begin
      step();
      o = obs(inst);
    end
    if (o[9:2] == 8'h00) begin
      timeout($sformatf("stream%0d_start", inst));
      return;
    end
    for (int c = 0; c < n; c++) begin
      code = codes[3*c +: 3];
      for (int h = 0; h < hold; h++) begin
        chk($sformatf("u%0d_drive_c%0d_h%0d", inst, c, h), 32'(obs(inst) >> 1), {23'd0, 8'b1 << code, 1'b0});
        step();
      end
      chk($sformatf("u%0d_gap_c%0d", inst, c), 32'(obs(inst) >> 1), {23'd0, 8'h00, 1'b1});
      step();
      chk($sformatf("u%0d_idle_c%0d", inst, c), 32'(obs(inst) >> 1), 32'd0);
      if (c == n - 1) begin
        if (end_empty) chk($sformatf("u%0d_busy_end", inst), 32'(obs(inst) & 10'd1), 32'd0);
      end else begin
        step();
      end
    end
  endtask

  initial begin
    // Reset and single code 5
    tbl[0]  = mk(0, 1, 0, 3'd0, 8'h00, 0, 0, 1, 3'd0);
    tbl[1]  = mk(1, 1, 1, 3'd5, 8'h00, 0, 1, 1, 3'd1);
    tbl[2]  = mk(1, 1, 0, 3'd0, 8'h20, 0, 1, 1, 3'd0);
    tbl[3]  = mk(1, 1, 0, 3'd0, 8'h20, 0, 1, 1, 3'd0);
    tbl[4]  = mk(1, 1, 0, 3'd0, 8'h20, 0, 1, 1, 3'd0);
    tbl[5]  = mk(1, 1, 0, 3'd0, 8'h20, 0, 1, 1, 3'd0);
    tbl[6]  = mk(1, 1, 0, 3'd0, 8'h00, 1, 1, 1, 3'd0);
    tbl[7]  = mk(1, 1, 0, 3'd0, 8'h00, 0, 0, 1, 3'd0);
    tbl[8]  = mk(1, 1, 0, 3'd0, 8'h00, 0, 0, 1, 3'd0);
    // Fill with en=0, fifth push refused, then raise en
    tbl[9]  = mk(0, 0, 0, 3'd0, 8'h00, 0, 0, 1, 3'd0);
    tbl[10] = mk(1, 0, 1, 3'd1, 8'h00, 0, 1, 1, 3'd1);
    tbl[11] = mk(1, 0, 1, 3'd2, 8'h00, 0, 1, 1, 3'd2);
    tbl[12] = mk(1, 0, 1, 3'd3, 8'h00, 0, 1, 1, 3'd3);
    tbl[13] = mk(1, 0, 1, 3'd4, 8'h00, 0, 1, 0, 3'd4);
    tbl[14] = mk(1, 0, 1, 3'd6, 8'h00, 0, 1, 0, 3'd4);
    tbl[15] = mk(1, 0, 0, 3'd0, 8'h00, 0, 1, 0, 3'd4);
    tbl[16] = mk(1, 1, 0, 3'd0, 8'h02, 0, 1, 1, 3'd3);

    #1;
    for (int i = 0; i < 17; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en;
      din_valid = tbl[i].vld; din = tbl[i].din;
      step();
      chk($sformatf("vec%0d", i), {17'd0, y0, done0, busy0, rdy0, level0},
          {17'd0, tbl[i].y, tbl[i].done, tbl[i].busy, tbl[i].rdy, tbl[i].level});
    end
    // Drain the filled FIFO in order; the refused code 6 must not appear
    check_stream(0, {12'd0, 3'd4, 3'd3, 3'd2, 3'd1}, 4, 4, 1'b1);
    chk("fill_level_end", 32'(level0), 32'd0);

    // Back-to-back 0..7
    do_reset();
    en = 1'b1;
    fork
      for (int i = 0; i < 8; i++) push(3'(i));
      check_stream(0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, 4, 1'b1);
    join

    // en drop mid-strobe
    do_reset();
    en = 1'b1;
    push(3'd3);
    push(3'd6);
    en = 1'b0;
    chk("endrop_launch", 32'(y0), 32'h08);
    check_stream(0, {21'd0, 3'd3}, 1, 4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("endrop_hold%0d", k), {22'd0, y0, level0[1:0]}, {22'd0, 8'h00, 2'd1});
    end
    en = 1'b1;
    step();
    chk("endrop_relaunch", 32'(y0), 32'h40);
    check_stream(0, {21'd0, 3'd6}, 1, 4, 1'b1);

    // Reset during DRIVE with two codes queued
    do_reset();
    en = 1'b1;
    push(3'd1);
    push(3'd2);
    push(3'd4);
    chk("midrst_pre", {21'd0, y0, level0}, {21'd0, 8'h02, 3'd2});
    rst_n = 1'b0;
    din_valid = 1'b1;
    din = 3'd7;
    step();
    rst_n = 1'b1;
    din_valid = 1'b0;
    chk("midrst_post", {17'd0, y0, done0, busy0, rdy0, level0},
        {17'd0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0});
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("midrst_quiet%0d", k), {22'd0, y0, done0, busy0}, 32'd0);
    end

    // Simultaneous push/pop at level 2, both HOLD=4 and HOLD=1
    do_reset();
    push(3'd5);
    push(3'd2);
    chk("simul_pre", {26'd0, level0, level1}, {26'd0, 3'd2, 3'd2});
    en = 1'b1;
    din = 3'd7;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("simul_level", {26'd0, level0, level1}, {26'd0, 3'd2, 3'd2});
    chk("simul_first", {16'd0, y0, y1}, {16'd0, 8'h20, 8'h20});
    fork
      check_stream(0, {15'd0, 3'd7, 3'd2, 3'd5}, 3, 4, 1'b1);
      check_stream(1, {15'd0, 3'd7, 3'd2, 3'd5}, 3, 1, 1'b1);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
